// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FiFo write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Ceiling log2, never less than 1 so single-entry ranges still get a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'(1) << addr_width;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotating-priority search: first set req bit at or after start, wrapping.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant_onehot,
  output logic          grant_valid
);

  always_comb begin
    int unsigned idx;
    idx          = 0;
    grant_onehot = '0;
    grant_valid  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(start) + k) % N;
      if (!grant_valid && req[IW'(idx)]) begin
        grant_onehot[IW'(idx)] = 1'b1;
        grant_valid            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FiFo write port, with an
// occupancy credit counter that covers the registered write in flight.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_BUS_SIZE = 32,
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ADDR_WIDTH    = 3,
  parameter int unsigned MAX_BURST     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*DATA_BUS_SIZE-1:0] wr_data,
  output logic [NUM_REQ-1:0]               ack,
  output logic                             fifo_wr,
  output logic [DATA_BUS_SIZE-1:0]         fifo_data,
  input  logic                             fifo_rd,
  input  logic                             fifo_empt,
  input  logic                             fifo_full,
  output logic [ADDR_WIDTH:0]              occupancy,
  output logic                             ovf_err
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int unsigned OW    = clog2(NUM_REQ);
  localparam int unsigned BW    = clog2(MAX_BURST + 1);
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  arb_state_e               state, state_n;
  logic [OW-1:0]            owner, owner_n, start_c, win_idx;
  logic [BW-1:0]            burst_cnt, burst_n;
  logic [NUM_REQ-1:0]       pick_oh, win_oh;
  logic                     pick_valid, space, cont, grant, dec;
  logic [DATA_BUS_SIZE-1:0] win_data, data_n;
  logic [CW-1:0]            occ_n;
  logic                     wr_n, ovf_n;

  assign start_c = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req          (req),
    .start        (start_c),
    .grant_onehot (pick_oh),
    .grant_valid  (pick_valid)
  );

  // Space comes from the registered count only: a same-cycle read frees a slot next cycle.
  assign space = (occupancy < CW'(DEPTH));
  assign cont  = (state == BURST) && req[owner] && (burst_cnt < BW'(MAX_BURST));
  assign grant = !rst && space && pick_valid;
  assign win_oh = cont ? (NUM_REQ'(1) << owner) : pick_oh;
  assign dec   = fifo_rd && !fifo_empt && (occupancy != '0);

  // One-hot winner to index and data mux.
  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_idx  = win_idx | OW'(i);
        win_data = win_data | wr_data[i*DATA_BUS_SIZE +: DATA_BUS_SIZE];
      end
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    burst_n = burst_cnt;
    ack     = '0;
    wr_n    = 1'b0;
    data_n  = fifo_data;
    occ_n   = occupancy;
    ovf_n   = ovf_err | (fifo_wr & fifo_full & ~fifo_rd);

    if (grant) begin
      ack     = win_oh;
      wr_n    = 1'b1;
      data_n  = win_data;
      state_n = BURST;
      if (cont) begin
        burst_n = burst_cnt + 1'b1;
      end else begin
        owner_n = win_idx;
        burst_n = BW'(1);
      end
    end else if (req == '0) begin
      state_n = IDLE;
      burst_n = '0;
    end

    if (grant && !dec) begin
      occ_n = occupancy + 1'b1;
    end else if (!grant && dec) begin
      occ_n = occupancy - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OW'(NUM_REQ - 1);
      burst_cnt <= '0;
      fifo_wr   <= 1'b0;
      fifo_data <= '0;
      occupancy <= '0;
      ovf_err   <= 1'b0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      burst_cnt <= burst_n;
      fifo_wr   <= wr_n;
      fifo_data <= data_n;
      occupancy <= occ_n;
      ovf_err   <= ovf_n;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a queue-level FiFo/arbiter model.
module tb_fifo_wr_arbiter;

  localparam int W     = 32;
  localparam int N     = 4;
  localparam int AW    = 3;
  localparam int MB    = 4;
  localparam int DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wr_data;
  logic [N-1:0]   ack;
  logic           fifo_wr;
  logic [W-1:0]   fifo_data;
  logic           fifo_rd, fifo_empt, fifo_full;
  logic [AW:0]    occupancy;
  logic           ovf_err;

  int checks   = 0;
  int failures = 0;

  int           m_owner, m_burst, m_occ, fcnt;
  bit           m_busy, m_ovf, m_wr, force_full;
  logic [W-1:0] m_data;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .DATA_BUS_SIZE (W),
    .NUM_REQ       (N),
    .ADDR_WIDTH    (AW),
    .MAX_BURST     (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .wr_data   (wr_data),
    .ack       (ack),
    .fifo_wr   (fifo_wr),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .fifo_empt (fifo_empt),
    .fifo_full (fifo_full),
    .occupancy (occupancy),
    .ovf_err   (ovf_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = N - 1;
    m_burst = 0;
    m_busy  = 1'b0;
    m_occ   = 0;
    m_ovf   = 1'b0;
    m_wr    = 1'b0;
    m_data  = '0;
    fcnt    = 0;
  endtask

  function automatic bit has_req(input logic [N-1:0] r, input int idx);
    logic [N-1:0] sh;
    sh = r >> idx;
    return sh[0];
  endfunction

  // Winner per the rules: keep the owner while its burst allows, else scan from owner+1.
  function automatic int pick(input logic [N-1:0] r, output bit cont);
    cont = 1'b0;
    if (m_busy && has_req(r, m_owner) && m_burst < MB) begin
      cont = 1'b1;
      return m_owner;
    end
    for (int k = 1; k <= N; k++) begin
      if (has_req(r, (m_owner + k) % N)) return (m_owner + k) % N;
    end
    return -1;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < N; i++) wr_data[i*W +: W] = $urandom;
  endtask

  task automatic step();
    bit           c, g, dec, push, pop;
    int           w;
    logic [W-1:0] word;
    @(negedge clk);
    w = pick(req, c);
    g = !rst && (m_occ < DEPTH) && (w >= 0);
    chk("ack", 64'(ack), g ? (64'd1 << w) : 64'd0);
    chk("fifo_wr", 64'(fifo_wr), 64'(m_wr));
    chk("fifo_data", 64'(fifo_data), 64'(m_data));
    chk("occupancy", 64'(occupancy), 64'(m_occ));
    chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
    word = g ? wr_data[w*W +: W] : '0;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      dec   = fifo_rd && !fifo_empt && (m_occ > 0);
      m_ovf = m_ovf | (m_wr && fifo_full && !fifo_rd);
      pop   = fifo_rd && (fcnt > 0);
      push  = m_wr && !fifo_full;
      fcnt  = fcnt + int'(push) - int'(pop);
      m_occ = m_occ + int'(g) - int'(dec);
      if (g) begin
        m_wr   = 1'b1;
        m_data = word;
        m_busy = 1'b1;
        if (c) m_burst++;
        else begin
          m_owner = w;
          m_burst = 1;
        end
      end else begin
        m_wr = 1'b0;
        if (req == '0) begin
          m_busy  = 1'b0;
          m_burst = 0;
        end
      end
    end
    #1;
    fifo_empt = (fcnt == 0);
    fifo_full = force_full || (fcnt >= DEPTH);
  endtask

  initial begin
    rst        = 1'b1;
    req        = '1;
    fifo_rd    = 1'b0;
    fifo_empt  = 1'b1;
    fifo_full  = 1'b0;
    force_full = 1'b0;
    rand_data();
    model_reset();
    #1;
    chk("rst_ack_comb", 64'(ack), 64'd0);
    @(posedge clk);
    #1;
    repeat (2) step();

    // First grant after reset release goes to requester 0.
    rst = 1'b0;
    #1;
    chk("first_grant", 64'(ack), 64'd1);
    step();

    // Single requester fills the FiFo to the credit limit.
    req = 4'b0001;
    repeat (12) begin
      rand_data();
      step();
    end
    chk("fill_occ", 64'(occupancy), 64'd8);
    chk("fill_ovf", 64'(ovf_err), 64'd0);

    // Reads from a full FiFo: one bubble, then grant and read balance.
    fifo_rd = 1'b1;
    repeat (4) begin
      rand_data();
      step();
    end
    chk("drain_occ", 64'(occupancy), 64'd7);

    // All requesters active with continuous reads: bursts of MB rotate.
    req = '1;
    repeat (24) begin
      rand_data();
      step();
    end

    // Randomized traffic at several read rates, with rare mid-run resets.
    for (int p = 0; p < 3; p++) begin
      repeat (150) begin
        if ($urandom_range(0, 99) < 30) req = N'($urandom);
        fifo_rd = ($urandom_range(0, 99) < (20 + 35 * p));
        rst     = ($urandom_range(0, 199) == 0);
        rand_data();
        step();
      end
      rst = 1'b0;
    end

    // Overflow flag: a write arriving while the FiFo reports full.
    rst     = 1'b1;
    req     = '0;
    fifo_rd = 1'b0;
    step();
    rst = 1'b0;
    req = 4'b0001;
    rand_data();
    step();
    req        = '0;
    force_full = 1'b1;
    fifo_full  = 1'b1;
    repeat (4) step();
    chk("ovf_set", 64'(ovf_err), 64'd1);
    rst        = 1'b1;
    force_full = 1'b0;
    fifo_full  = 1'b0;
    step();
    chk("ovf_clear", 64'(ovf_err), 64'd0);
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
